// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nsa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIBBLE = 4;

    function automatic int num_steps(input int width);
        return width / NIBBLE;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_cla4.sv
// 4-bit carry-lookahead slice, purely combinational.
// Exports c3 (carry into bit 3) so the parent can form signed overflow.
module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co,
    output logic       c3
);

    logic [3:0] w_p;
    logic [3:0] w_g;
    logic [4:0] w_c;

    assign w_p = a ^ b;
    assign w_g = a & b;

    assign w_c[0] = ci;
    assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
    assign w_c[2] = w_g[1] | (w_p[1] & w_c[1]);
    assign w_c[3] = w_g[2] | (w_p[2] & w_c[2]);
    assign w_c[4] = w_g[3] | (w_p[3] & w_c[3]);

    assign s  = w_p ^ w_c[3:0];
    assign co = w_c[4];
    assign c3 = w_c[3];

endmodule

// File: rtl/nibble_serial_adder.sv
// Serial WIDTH-bit adder, one nibble per cycle; result valid WIDTH/4 cycles after accept.
// Result held in DONE until out_ready; no new operands accepted until then.
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ov,
    output logic             busy
);

    localparam int N  = num_steps(WIDTH);
    localparam int SW = $clog2(N);
    localparam logic [SW-1:0] LAST = SW'(N - 1);

    generate
        if ((WIDTH % NIBBLE) != 0 || WIDTH < 8) begin : g_bad_width
            $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 8");
        end
    endgenerate

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_c_msb;
    logic [SW-1:0]    r_step;

    logic [3:0]       w_s;
    logic             w_co;
    logic             w_c3;
    logic             w_last;

    assign w_last = (r_step == LAST);

    // Operands shift right so the slice always sees the current nibble at [3:0];
    // sum nibbles enter from the top and land in place after N steps.
    cla4 u_cla4 (
        .a  (r_a[NIBBLE-1:0]),
        .b  (r_b[NIBBLE-1:0]),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co),
        .c3 (w_c3)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_nxt = RUN;
            RUN:     if (w_last)    w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
        busy      = (r_state == RUN) || (r_state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_c_msb <= 1'b0;
            r_step  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= ci;
                        r_sum   <= '0;
                        r_c_msb <= 1'b0;
                        r_step  <= '0;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> NIBBLE;
                    r_b     <= r_b >> NIBBLE;
                    r_sum   <= {w_s, r_sum[WIDTH-1:NIBBLE]};
                    r_carry <= w_co;
                    r_step  <= r_step + 1'b1;
                    if (w_last) begin
                        r_c_msb <= w_c3;
                    end
                end
                default: ;
            endcase
        end
    end

    assign s  = r_sum;
    assign co = r_carry;
    assign ov = r_carry ^ r_c_msb;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: directed literal cases plus random traffic
// checked every cycle against an arithmetic reference queue.
module tb_nibble_serial_adder;

    localparam int W = 16;
    localparam int N = W / 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ci = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    logic         busy;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    typedef struct {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
        int           acc;
    } exp_t;

    exp_t q[$];
    logic prev_valid = 1'b0;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .co        (co),
        .ov        (ov),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic c, input int acc);
        exp_t        e;
        logic [W:0]  full;
        full  = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        e.s   = full[W-1:0];
        e.co  = full[W];
        e.ov  = (x[W-1] == y[W-1]) && (e.s[W-1] != x[W-1]);
        e.acc = acc;
        return e;
    endfunction

    // Monitor: inputs are driven just after posedge, so at negedge they show
    // exactly what the next rising edge will act on.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 1);
            chk("rst_busy", busy, 0);
            chk("rst_s", s, 0);
            chk("rst_co", co, 0);
            chk("rst_ov", ov, 0);
            q.delete();
            prev_valid <= 1'b0;
        end else begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_out_valid", out_valid, 0);
                end else begin
                    if (!prev_valid) chk("latency", cyc - q[0].acc - 1, N);
                    chk("s", s, q[0].s);
                    chk("co", co, q[0].co);
                    chk("ov", ov, q[0].ov);
                    chk("in_ready_in_done", in_ready, 0);
                    chk("busy_in_done", busy, 1);
                    if (out_ready) void'(q.pop_front());
                end
            end else if (busy) begin
                chk("in_ready_in_run", in_ready, 0);
            end
            if (in_valid && in_ready) q.push_back(model(a, b, ci, cyc));
            prev_valid <= out_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_b, input logic tci,
                         input logic [W-1:0] es, input logic eco, input logic eov,
                         input int hold, input bit poke);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin tick(); n++; end
        chk("dir_wait_ready", in_ready, 1);
        a = ta; b = tb_b; ci = tci; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        if (poke) begin a = ~ta; b = 16'h5A5A; ci = ~tci; end
        n = 0;
        while (!out_valid && n < 50) begin tick(); n++; end
        chk("dir_latency", n, N);
        chk("dir_out_valid", out_valid, 1);
        chk("dir_s", s, es);
        chk("dir_co", co, eco);
        chk("dir_ov", ov, eov);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; a = W'($urandom); b = W'($urandom);
            tick();
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_s", s, es);
            chk("bp_co", co, eco);
            chk("bp_ov", ov, eov);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("hs_out_valid_low", out_valid, 0);
        chk("hs_in_ready_high", in_ready, 1);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 2, 1'b0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0, 1'b0);
        do_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 0, 1'b0);
        do_op(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 0, 1'b1);
        do_op(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 3, 1'b0);

        // Abort mid-RUN: reset lands after step 2.
        a = 16'h1234; b = 16'h1111; ci = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_s", s, 0);
        tick();
        rst_n = 1'b1;
        tick();
        do_op(16'h0F0F, 16'hF0F1, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0);

        for (int i = 0; i < 30000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            a         = W'($urandom);
            b         = W'($urandom);
            ci        = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 1) != 0);
            tick();
        end

        in_valid = 1'b0; out_ready = 1'b1;
        repeat (2 * N + 4) tick();
        chk("drain_queue_empty", q.size(), 0);
        chk("drain_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
